button_poll_master: RTL and testbench

- Avalon-MM read-only master that periodically polls the 2-bit push-button PIO slave (offset 0 = data register).
- Debounces each sampled bit, maintains a stable button state, and emits one-cycle press/release pulses plus a sticky interrupt.
- Sits between the Qsys interconnect (master side) and the game/controller logic, which therefore never has to poll the PIO over the bus itself.

---
 rtl/button_poll_master.sv | 153 +++++++++++++++
 tb/tb_button_poll_master.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/button_poll_master.sv
// Avalon-MM read master that polls a 2-bit push-button PIO, debounces each bit,
// and reports stable state, press/release pulses, a sticky irq and a sticky bus error.
module button_poll_master #(
    parameter int unsigned POLL_CYCLES      = 50000,
    parameter int unsigned DEBOUNCE_SAMPLES = 4,
    parameter int unsigned TIMEOUT_CYCLES   = 256,
    parameter int unsigned ACTIVE_LOW       = 1,
    parameter int unsigned BASE_ADDR        = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    output logic [31:0] avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic [1:0]  btn_state,
    output logic [1:0]  btn_press,
    output logic [1:0]  btn_release,
    output logic        irq,
    input  logic        irq_ack,
    output logic        bus_error
);

    localparam int unsigned TIMER_W = (POLL_CYCLES > 2) ? $clog2(POLL_CYCLES) : 2;
    localparam int unsigned TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned CNT_W   = 4;

    localparam logic [TIMER_W-1:0] TIMER_RELOAD = TIMER_W'(POLL_CYCLES - 1);
    localparam logic [TO_W-1:0]    TO_LAST      = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]   DEB_TARGET   = CNT_W'(DEBOUNCE_SAMPLES);
    localparam logic [1:0]         INV_MASK     = (ACTIVE_LOW != 0) ? 2'b11 : 2'b00;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, UPDATE} state_t;

    state_t                  state;
    logic [TIMER_W-1:0]      timer;
    logic [TO_W-1:0]         tcnt;
    logic [1:0]              raw;
    logic [1:0]              cand;
    logic [1:0][CNT_W-1:0]   cnt;

    logic [1:0]              state_nxt;
    logic [1:0]              cand_nxt;
    logic [1:0][CNT_W-1:0]   cnt_nxt;
    logic [1:0][CNT_W-1:0]   cnt_inc;

    logic                    unused_readdata;

    assign avm_address     = 32'(BASE_ADDR);
    assign unused_readdata = ^avm_readdata[31:2];

    // Per-bit debounce step applied to the sample captured for this poll
    always_comb begin
        state_nxt = btn_state;
        cand_nxt  = cand;
        cnt_nxt   = cnt;
        cnt_inc   = '0;
        for (int i = 0; i < 2; i++) begin
            if (raw[i] != btn_state[i]) begin
                if (raw[i] == cand[i]) begin
                    cnt_inc[i] = (cnt[i] == {CNT_W{1'b1}}) ? cnt[i] : cnt[i] + CNT_W'(1);
                end else begin
                    cand_nxt[i] = raw[i];
                    cnt_inc[i]  = CNT_W'(1);
                end
                if (cnt_inc[i] == DEB_TARGET) begin
                    state_nxt[i] = raw[i];
                    cnt_nxt[i]   = '0;
                end else begin
                    cnt_nxt[i] = cnt_inc[i];
                end
            end else begin
                cnt_nxt[i] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            timer       <= TIMER_RELOAD;
            tcnt        <= '0;
            raw         <= '0;
            cand        <= '0;
            cnt         <= '0;
            avm_read    <= 1'b0;
            btn_state   <= '0;
            btn_press   <= '0;
            btn_release <= '0;
            irq         <= 1'b0;
            bus_error   <= 1'b0;
        end else begin
            btn_press   <= '0;
            btn_release <= '0;

            // Timer runs in every state; at zero it waits for IDLE (deferred poll)
            if (enable && timer != '0) begin
                timer <= timer - TIMER_W'(1);
            end

            if (btn_press != 2'b00) begin
                irq <= 1'b1;
            end else if (irq_ack) begin
                irq <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (enable && timer == '0) begin
                        state    <= REQ;
                        avm_read <= 1'b1;
                        timer    <= TIMER_RELOAD;
                    end
                end
                REQ: begin
                    if (!avm_waitrequest) begin
                        avm_read <= 1'b0;
                        tcnt     <= '0;
                        if (avm_readdatavalid) begin
                            raw   <= avm_readdata[1:0] ^ INV_MASK;
                            state <= UPDATE;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (avm_readdatavalid) begin
                        raw   <= avm_readdata[1:0] ^ INV_MASK;
                        state <= UPDATE;
                    end else if (tcnt == TO_LAST) begin
                        bus_error <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        tcnt <= tcnt + TO_W'(1);
                    end
                end
                UPDATE: begin
                    btn_state   <= state_nxt;
                    cand        <= cand_nxt;
                    cnt         <= cnt_nxt;
                    btn_press   <= state_nxt & ~btn_state;
                    btn_release <= ~state_nxt & btn_state;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_button_poll_master.sv
// Directed bench for button_poll_master: table of polls with expected debounce
// results, plus hand sequences for bus timeout and reset during a transaction.
module tb_button_poll_master;

    localparam int unsigned POLL = 64;
    localparam int unsigned DEB  = 4;
    localparam int unsigned TOUT = 32;
    localparam logic [31:0] BASE = 32'h0000_0040;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;
    logic [1:0]  btn_state;
    logic [1:0]  btn_press;
    logic [1:0]  btn_release;
    logic        irq;
    logic        irq_ack;
    logic        bus_error;

    button_poll_master #(
        .POLL_CYCLES(POLL), .DEBOUNCE_SAMPLES(DEB), .TIMEOUT_CYCLES(TOUT),
        .ACTIVE_LOW(1), .BASE_ADDR(BASE)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .avm_address(avm_address), .avm_read(avm_read),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid),
        .btn_state(btn_state), .btn_press(btn_press), .btn_release(btn_release),
        .irq(irq), .irq_ack(irq_ack), .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0] data;
        int         ws;
        bit         same;
        bit         ack_during;
        int         off;
        logic [1:0] st;
        logic [1:0] press;
        logic [1:0] rel;
    } row_t;

    row_t rows[28];
    int   n_cmp = 0;
    int   n_err = 0;
    int   last_req;
    int   exp_period;
    logic exp_bus_err;

    function automatic row_t mk(input logic [1:0] d, input int ws, input bit same,
                                input bit ackd, input int off, input logic [1:0] st,
                                input logic [1:0] p, input logic [1:0] rl);
        row_t r;
        r.data = d; r.ws = ws; r.same = same; r.ack_during = ackd; r.off = off;
        r.st = st; r.press = p; r.rel = rl;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_req(output bit seen);
        int k = 0;
        while (!avm_read && k < exp_period + 4) begin
            @(negedge clk);
            k++;
        end
        seen = avm_read;
        check("req_seen", 32'(avm_read), 32'd1);
        if (seen) begin
            check("poll_period", 32'(cyc - last_req), 32'(exp_period));
            last_req   = cyc;
            exp_period = POLL;
        end
    endtask

    // Runs the address phase; optionally returns data in the accept cycle
    task automatic handshake(input int ws, input bit same, input logic [1:0] d);
        int hi = 0;
        while (avm_read && hi < ws + 3) begin
            hi++;
            avm_waitrequest = (hi <= ws);
            if (hi == ws + 1 && same) begin
                avm_readdatavalid = 1'b1;
                avm_readdata      = 32'hDEAD_BEE0 | 32'(d);
            end
            @(negedge clk);
        end
        avm_waitrequest = 1'b0;
        check("read_cycles", 32'(hi), 32'(ws + 1));
    endtask

    task automatic poll(input row_t r);
        bit seen;
        irq_ack = r.ack_during;
        if (r.off > 0) begin
            enable = 1'b0;
            repeat (r.off) @(negedge clk);
            enable     = 1'b1;
            exp_period = POLL + r.off;
        end
        wait_req(seen);
        if (!seen) return;
        handshake(r.ws, r.same, r.data);
        if (!r.same) begin
            @(negedge clk);
            avm_readdatavalid = 1'b1;
            avm_readdata      = 32'hDEAD_BEE0 | 32'(r.data);
            @(negedge clk);
        end
        avm_readdatavalid = 1'b0;
        @(negedge clk);
        check("btn_state", 32'(btn_state), 32'(r.st));
        check("btn_press", 32'(btn_press), 32'(r.press));
        check("btn_release", 32'(btn_release), 32'(r.rel));
        @(negedge clk);
        check("press_width", 32'(btn_press), 32'd0);
        check("release_width", 32'(btn_release), 32'd0);
        check("irq_set", 32'(irq), 32'(r.press != 2'b00));
        check("bus_error", 32'(bus_error), 32'(exp_bus_err));
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        check("irq_ack", 32'(irq), 32'd0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_read"}, 32'(avm_read), 32'd0);
        check({tag, "_state"}, 32'(btn_state), 32'd0);
        check({tag, "_press"}, 32'(btn_press), 32'd0);
        check({tag, "_release"}, 32'(btn_release), 32'd0);
        check({tag, "_irq"}, 32'(irq), 32'd0);
        check({tag, "_bus_error"}, 32'(bus_error), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        bit seen;
        int k;

        rows[0]  = mk(2'd3, 0,  0, 0, 0, 2'b00, 2'b00, 2'b00);
        rows[1]  = mk(2'd3, 10, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        rows[2]  = mk(2'd2, 0,  0, 0, 0, 2'b00, 2'b00, 2'b00);
        rows[3]  = mk(2'd2, 0,  1, 0, 0, 2'b00, 2'b00, 2'b00);
        rows[4]  = mk(2'd2, 0,  0, 0, 0, 2'b00, 2'b00, 2'b00);
        rows[5]  = mk(2'd2, 0,  0, 0, 0, 2'b01, 2'b01, 2'b00);
        rows[6]  = mk(2'd0, 0,  0, 0, 0, 2'b01, 2'b00, 2'b00);
        rows[7]  = mk(2'd2, 0,  0, 0, 0, 2'b01, 2'b00, 2'b00);
        rows[8]  = mk(2'd0, 0,  0, 0, 0, 2'b01, 2'b00, 2'b00);
        rows[9]  = mk(2'd0, 0,  0, 0, 0, 2'b01, 2'b00, 2'b00);
        rows[10] = mk(2'd0, 0,  0, 0, 0, 2'b01, 2'b00, 2'b00);
        rows[11] = mk(2'd0, 0,  0, 0, 0, 2'b11, 2'b10, 2'b00);
        rows[12] = mk(2'd3, 0,  0, 0, 0, 2'b11, 2'b00, 2'b00);
        rows[13] = mk(2'd3, 0,  0, 0, 0, 2'b11, 2'b00, 2'b00);
        rows[14] = mk(2'd3, 0,  0, 0, 0, 2'b11, 2'b00, 2'b00);
        rows[15] = mk(2'd3, 0,  0, 0, 0, 2'b00, 2'b00, 2'b11);
        rows[16] = mk(2'd0, 0,  0, 0, 0, 2'b00, 2'b00, 2'b00);
        rows[17] = mk(2'd0, 3,  0, 0, 0, 2'b00, 2'b00, 2'b00);
        rows[18] = mk(2'd0, 0,  0, 0, 0, 2'b00, 2'b00, 2'b00);
        rows[19] = mk(2'd0, 0,  0, 1, 0, 2'b11, 2'b11, 2'b00);
        rows[20] = mk(2'd3, 0,  0, 0, 0, 2'b11, 2'b00, 2'b00);
        rows[21] = mk(2'd3, 0,  0, 0, 0, 2'b11, 2'b00, 2'b00);
        rows[22] = mk(2'd3, 0,  0, 0, 0, 2'b11, 2'b00, 2'b00);
        rows[23] = mk(2'd3, 0,  0, 0, 0, 2'b00, 2'b00, 2'b11);
        rows[24] = mk(2'd1, 0,  0, 0, 7, 2'b00, 2'b00, 2'b00);
        rows[25] = mk(2'd1, 0,  0, 0, 0, 2'b00, 2'b00, 2'b00);
        rows[26] = mk(2'd1, 0,  0, 0, 0, 2'b00, 2'b00, 2'b00);
        rows[27] = mk(2'd1, 0,  0, 0, 0, 2'b10, 2'b10, 2'b00);

        reset_n = 1'b0; enable = 1'b0; irq_ack = 1'b0;
        avm_waitrequest = 1'b0; avm_readdata = '0; avm_readdatavalid = 1'b0;
        exp_bus_err = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        check("address", avm_address, BASE);
        reset_n    = 1'b1;
        enable     = 1'b1;
        last_req   = cyc;
        exp_period = POLL;

        for (int i = 0; i <= 20; i++) poll(rows[i]);

        // Slave never answers: timeout, sticky bus_error, debounce untouched
        wait_req(seen);
        if (seen) begin
            handshake(0, 1'b0, 2'd0);
            k = 0;
            while (!bus_error && k < int'(TOUT) + 8) begin
                @(negedge clk);
                k++;
            end
            check("timeout_cycles", 32'(k), 32'(TOUT));
            check("timeout_read", 32'(avm_read), 32'd0);
            check("timeout_state", 32'(btn_state), 32'b11);
            exp_bus_err = 1'b1;
        end

        for (int i = 21; i < 28; i++) poll(rows[i]);

        // Reset during WAIT, then stale readdatavalid must be ignored
        wait_req(seen);
        if (seen) begin
            handshake(0, 1'b0, 2'd0);
            @(negedge clk);
            reset_n = 1'b0;
            @(negedge clk);
            check_zero("midreset");
            @(negedge clk);
            reset_n           = 1'b1;
            last_req          = cyc;
            exp_period        = POLL;
            exp_bus_err       = 1'b0;
            avm_readdatavalid = 1'b1;
            avm_readdata      = 32'h0;
            @(negedge clk);
            avm_readdatavalid = 1'b0;
            @(negedge clk);
            check_zero("late_data");
            poll(mk(2'd3, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
